// File: rtl/icache_line_fetch.sv
// icache_line_fetch: pops one fetch request and fills the whole cache line
// with single-word reads, critical word first, wrapping inside the line.
module icache_line_fetch #(
    parameter int DATABITS     = 32,
    parameter int ADDRBITS     = 32,
    parameter int LINEWORDBITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                queue_not_empty,
    input  logic [ADDRBITS-1:0] queue_out_addr,
    input  logic [1:0]          queue_out_wordlen,
    output logic                queue_pop,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic                mem_rdreq,
    input  logic                mem_ack,
    input  logic                mem_rdvalid,
    input  logic [DATABITS-1:0] mem_rddata,
    output logic                fill_we,
    output logic [ADDRBITS-1:0] fill_addr,
    output logic [DATABITS-1:0] fill_data,
    output logic [1:0]          fill_wordlen,
    output logic                fill_done,
    output logic                busy
);

    localparam int OFFBITS = LINEWORDBITS + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              r_state;
    logic [ADDRBITS-1:0]     r_base;
    logic [LINEWORDBITS-1:0] r_start;
    logic [LINEWORDBITS-1:0] r_cnt;
    logic [1:0]              r_wordlen;
    logic                    r_fill_we;
    logic [ADDRBITS-1:0]     r_fill_addr;
    logic [DATABITS-1:0]     r_fill_data;
    logic                    r_fill_done;

    logic [LINEWORDBITS-1:0] w_idx;
    logic [ADDRBITS-1:0]     w_word_addr;
    logic [ADDRBITS-1:0]     w_head_base;
    logic                    w_word_done;
    logic                    w_last;
    logic [1:0]              w_after_word;
    logic                    w_unused;

    // Word index wraps within the line; the base is never advanced.
    assign w_idx       = r_start + r_cnt;
    assign w_head_base = {queue_out_addr[ADDRBITS-1:OFFBITS], {OFFBITS{1'b0}}};
    assign w_last      = &r_cnt;
    assign w_after_word = w_last ? S_DONE : S_REQ;
    assign w_word_done = mem_rdvalid &
                         ((r_state == S_WAIT) |
                          ((r_state == S_REQ) & mem_ack));
    assign w_unused    = ^queue_out_addr[1:0];

    // Splice the wrapped word index into the line base.
    always_comb begin
        w_word_addr = r_base;
        w_word_addr[OFFBITS-1:2] = w_idx;
    end

    // Pop is the only output that looks at inputs; it is masked in reset.
    assign queue_pop    = reset_n & (r_state == S_IDLE) & queue_not_empty;
    assign mem_rdreq    = (r_state == S_REQ);
    assign mem_addr     = w_word_addr;
    assign busy         = (r_state != S_IDLE);
    assign fill_we      = r_fill_we;
    assign fill_addr    = r_fill_addr;
    assign fill_data    = r_fill_data;
    assign fill_wordlen = r_wordlen;
    assign fill_done    = r_fill_done;

    // Line-fill sequencer: accept a request, issue reads, then signal done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_start     <= '0;
            r_cnt       <= '0;
            r_wordlen   <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (queue_not_empty) begin
                        r_base    <= w_head_base;
                        r_start   <= queue_out_addr[OFFBITS-1:2];
                        r_wordlen <= queue_out_wordlen;
                        r_cnt     <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state <= mem_rdvalid ? w_after_word : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rdvalid) begin
                        r_state <= w_after_word;
                    end
                end
                default: begin
                    if (r_fill_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_fill_done <= 1'b1;
                    end
                end
            endcase
            if (w_word_done) begin
                r_cnt <= r_cnt + LINEWORDBITS'(1);
            end
        end
    end

    // Fill port: one registered write per returned word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_we   <= 1'b0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
        end else begin
            r_fill_we <= w_word_done;
            if (w_word_done) begin
                r_fill_addr <= w_word_addr;
                r_fill_data <= mem_rddata;
            end
        end
    end

endmodule

// File: tb/tb_icache_line_fetch.sv
// tb_icache_line_fetch: random memory timing and request stream checked
// against a transaction-level model of the line fill, plus directed cases.
module tb_icache_line_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        queue_not_empty;
    logic [31:0] queue_out_addr;
    logic [1:0]  queue_out_wordlen;
    logic        queue_pop;
    logic [31:0] mem_addr;
    logic        mem_rdreq;
    logic        mem_ack;
    logic        mem_rdvalid;
    logic [31:0] mem_rddata;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic [1:0]  fill_wordlen;
    logic        fill_done;
    logic        busy;

    icache_line_fetch #(
        .DATABITS(32),
        .ADDRBITS(32),
        .LINEWORDBITS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .queue_not_empty(queue_not_empty),
        .queue_out_addr(queue_out_addr),
        .queue_out_wordlen(queue_out_wordlen),
        .queue_pop(queue_pop),
        .mem_addr(mem_addr),
        .mem_rdreq(mem_rdreq),
        .mem_ack(mem_ack),
        .mem_rdvalid(mem_rdvalid),
        .mem_rddata(mem_rddata),
        .fill_we(fill_we),
        .fill_addr(fill_addr),
        .fill_data(fill_data),
        .fill_wordlen(fill_wordlen),
        .fill_done(fill_done),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                      nm, act, exp, $time);
    endtask

    // Request queue feeding the DUT.
    typedef struct {
        logic [31:0] a;
        logic [1:0]  wl;
    } req_t;
    req_t rq[$];
    logic pop_seen = 1'b0;

    always @(posedge clk) pop_seen <= queue_pop;

    // Memory responder state.
    bit pending = 0;
    int dwait = 0;
    int await_cnt = 0;
    int ack_lo = 0, ack_hi = 0, lat_lo = 0, lat_hi = 0;
    bit stray = 0;

    // Transaction-level model of one line fill.
    bit          m_active = 0;
    bit          m_issue  = 0;
    int          m_k      = 0;
    int          m_fin    = 0;
    int          m_start  = 0;
    logic [31:0] m_base   = '0;
    bit          e_fill_we = 0;
    bit          e_done    = 0;
    logic [31:0] e_fill_addr = '0;
    logic [31:0] e_fill_data = '0;
    logic [1:0]  e_wl = '0;
    bit          exp_rdreq;

    // Observation logs for the directed cases.
    logic [31:0] log_acc[$];
    logic [31:0] log_fill[$];
    logic [1:0]  log_wl[$];
    int          log_pop[$];
    int          log_done[$];
    int          n_rdreq = 0;
    int          n_busy  = 0;

    function automatic logic [31:0] word_addr(input int k);
        return m_base + 32'(((m_start + k) % 4) * 4);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model update on every clock edge and on reset.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_active = 0; m_issue = 0; m_k = 0; m_fin = 0;
            e_fill_we = 0; e_done = 0; e_wl = '0;
            e_fill_addr = '0; e_fill_data = '0;
        end else begin
            e_fill_we = 0;
            e_done = 0;
            if (!m_active) begin
                if (queue_not_empty) begin
                    m_active = 1;
                    m_base  = queue_out_addr & 32'hFFFF_FFF0;
                    m_start = int'(queue_out_addr[3:2]);
                    e_wl    = queue_out_wordlen;
                    m_k     = 0;
                    m_issue = 1;
                end
            end else if (m_fin > 0) begin
                if (m_fin == 2) begin
                    m_fin  = 1;
                    e_done = 1;
                end else begin
                    m_fin    = 0;
                    m_active = 0;
                end
            end else if ((m_issue && mem_ack && mem_rdvalid) ||
                         (!m_issue && mem_rdvalid)) begin
                e_fill_we   = 1;
                e_fill_addr = word_addr(m_k);
                e_fill_data = mem_rddata;
                m_k++;
                if (m_k == 4) begin
                    m_issue = 0;
                    m_fin   = 2;
                end else begin
                    m_issue = 1;
                end
            end else if (m_issue && mem_ack) begin
                m_issue = 0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("queue_pop", queue_pop, reset_n && !m_active && queue_not_empty);
        chk("busy", busy, m_active);
        exp_rdreq = m_active && (m_fin == 0) && m_issue;
        chk("mem_rdreq", mem_rdreq, exp_rdreq);
        if (exp_rdreq) chk("mem_addr", mem_addr, word_addr(m_k));
        chk("fill_we", fill_we, e_fill_we);
        if (e_fill_we) begin
            chk("fill_addr", fill_addr, e_fill_addr);
            chk("fill_data", fill_data, e_fill_data);
        end
        if (m_active) chk("fill_wordlen", fill_wordlen, e_wl);
        chk("fill_done", fill_done, e_done);
        if (mem_rdreq && mem_ack) log_acc.push_back(mem_addr);
        if (fill_we) begin
            log_fill.push_back(fill_addr);
            log_wl.push_back(fill_wordlen);
        end
        if (queue_pop) log_pop.push_back(cyc);
        if (fill_done) log_done.push_back(cyc);
        n_rdreq += int'(mem_rdreq);
        n_busy  += int'(busy);
    end

    task automatic drive_queue();
        queue_not_empty = (rq.size() > 0);
        if (rq.size() > 0) begin
            queue_out_addr    = rq[0].a;
            queue_out_wordlen = rq[0].wl;
        end else begin
            queue_out_addr    = $urandom;
            queue_out_wordlen = 2'($urandom);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] wl);
        req_t r;
        r.a = a;
        r.wl = wl;
        rq.push_back(r);
        drive_queue();
    endtask

    task automatic set_mode(input int al, input int ah, input int ll,
                            input int lh, input bit s);
        ack_lo = al; ack_hi = ah; lat_lo = ll; lat_hi = lh; stray = s;
        await_cnt = int'($urandom_range(ah, al));
    endtask

    task automatic respond();
        int lat;
        mem_ack = 0;
        mem_rdvalid = 0;
        mem_rddata = $urandom;
        if (!reset_n) begin
            pending = 0;
        end else if (pending) begin
            if (dwait == 0) begin
                mem_rdvalid = 1;
                pending = 0;
            end else begin
                dwait--;
            end
        end else if (mem_rdreq) begin
            if (await_cnt == 0) begin
                mem_ack = 1;
                lat = int'($urandom_range(lat_hi, lat_lo));
                if (lat == 0) begin
                    mem_rdvalid = 1;
                end else begin
                    pending = 1;
                    dwait = lat - 1;
                end
                await_cnt = int'($urandom_range(ack_hi, ack_lo));
            end else begin
                await_cnt--;
                mem_rdvalid = stray;
            end
        end else begin
            mem_rdvalid = stray;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen && rq.size() > 0) void'(rq.pop_front());
        drive_queue();
        respond();
    endtask

    task automatic clear_logs();
        log_acc.delete();
        log_fill.delete();
        log_wl.delete();
        log_pop.delete();
        log_done.delete();
        n_rdreq = 0;
        n_busy  = 0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((rq.size() > 0 || busy) && n < budget);
        chk(nm, (rq.size() == 0 && !busy), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pop"}, queue_pop, 0);
        chk({tag, "_rdreq"}, mem_rdreq, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_we"}, fill_we, 0);
        chk({tag, "_faddr"}, fill_addr, 0);
        chk({tag, "_fdata"}, fill_data, 0);
        chk({tag, "_fwl"}, fill_wordlen, 0);
        chk({tag, "_done"}, fill_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        reset_n = 0;
        mem_ack = 0;
        mem_rdvalid = 0;
        mem_rddata = '0;
        set_mode(0, 0, 0, 0, 0);
        drive_queue();
        repeat (2) @(posedge clk);
        #2;

        // Reset values, with a request already waiting.
        push(32'h1000, 2'd0);
        #1;
        check_zero("rst");

        // Aligned fill with zero-latency memory.
        clear_logs();
        tick();
        reset_n = 1;
        wait_idle(100, "t1_timeout");
        chk("t1_nacc", log_acc.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t1_acc", log_acc[i], 32'h1000 + 32'(4 * i));
        chk("t1_nfill", log_fill.size(), 4);
        chk("t1_npop", log_pop.size(), 1);
        chk("t1_ndone", log_done.size(), 1);
        chk("t1_latency", log_done[0] - log_pop[0], 6);

        // Critical word first, wrapping inside the line.
        clear_logs();
        push(32'h200C, 2'd3);
        wait_idle(100, "t2_timeout");
        chk("t2_nfill", log_fill.size(), 4);
        chk("t2_f0", log_fill[0], 32'h200C);
        chk("t2_f1", log_fill[1], 32'h2000);
        chk("t2_f2", log_fill[2], 32'h2004);
        chk("t2_f3", log_fill[3], 32'h2008);

        // Back-pressure with stray rdvalid in idle and unacked request.
        set_mode(3, 3, 2, 2, 1);
        clear_logs();
        repeat (5) tick();
        push(32'h3010, 2'd1);
        wait_idle(200, "t3_timeout");
        chk("t3_rdreq_cycles", n_rdreq, 16);
        chk("t3_nfill", log_fill.size(), 4);
        chk("t3_f0", log_fill[0], 32'h3010);

        // Back-to-back requests.
        set_mode(0, 0, 0, 0, 0);
        clear_logs();
        push(32'h0040, 2'd2);
        push(32'h0080, 2'd1);
        wait_idle(100, "t4_timeout");
        chk("t4_npop", log_pop.size(), 2);
        chk("t4_pop2", log_pop[1], log_done[0] + 1);
        chk("t4_nfill", log_fill.size(), 8);
        chk("t4_wl0", log_wl[0], 2);
        chk("t4_wl1", log_wl[4], 1);

        // Reset while waiting on the third word.
        set_mode(0, 0, 2, 2, 0);
        clear_logs();
        push(32'h3000, 2'd0);
        push(32'h3048, 2'd3);
        n = 0;
        while (!(log_fill.size() == 2 && pending) && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach_wait", n < 100, 1);
        #1;
        reset_n = 0;
        mem_ack = 0;
        mem_rdvalid = 0;
        #1;
        check_zero("t5rst");
        repeat (3) tick();
        reset_n = 1;
        wait_idle(100, "t5_timeout");
        chk("t5_nfill", log_fill.size(), 6);
        chk("t5_ndone", log_done.size(), 1);
        chk("t5_f2", log_fill[2], 32'h3048);
        chk("t5_f5", log_fill[5], 32'h3044);
        chk("t5_wl", log_wl[2], 3);

        // Empty queue with stray rdvalid.
        set_mode(0, 0, 0, 0, 1);
        clear_logs();
        repeat (20) tick();
        chk("t6_npop", log_pop.size(), 0);
        chk("t6_rdreq", n_rdreq, 0);
        chk("t6_busy", n_busy, 0);

        // Randomised request stream and memory timing.
        for (int b = 0; b < 6; b++) begin
            set_mode(0, int'($urandom_range(3, 0)), 0,
                     int'($urandom_range(3, 0)), bit'($urandom % 2));
            clear_logs();
            for (int i = 0; i < 8; i++) begin
                push($urandom, 2'($urandom));
                repeat ($urandom_range(6, 0)) tick();
            end
            wait_idle(3000, "rand_timeout");
            chk("rand_ndone", log_done.size(), 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/icache_line_fetch.md
# icache_line_fetch

Consumer end of the instruction-cache request queue. Pops one fetch request at a time, turns it into a line fill of LINEWORDS single-word memory reads (critical word first, wrapping within the line), and writes each returned word into the cache data array through a fill port. Sits between the request queue and the memory bus arbiter.

## Interface
- DATABITS, 32, data word width
- ADDRBITS, 32, byte address width
- LINEWORDBITS, 2, log2 of words per line (LINEWORDS=2**LINEWORDBITS)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- queue_not_empty  in  1  queue holds at least one request
- queue_out_addr  in  ADDRBITS  head request byte address (combinational from queue)
- queue_out_wordlen  in  2  head request word length, carried as metadata
- queue_pop  out  1  advance queue head
- mem_addr  out  ADDRBITS  word-aligned read address
- mem_rdreq  out  1  read request, held until accepted
- mem_ack  in  1  request accepted this cycle
- mem_rdvalid  in  1  read data valid
- mem_rddata  in  DATABITS  read data
- fill_we  out  1  write one word into the line buffer
- fill_addr  out  ADDRBITS  word-aligned address of the written word
- fill_data  out  DATABITS  word written
- fill_wordlen  out  2  wordlen of the current request
- fill_done  out  1  one-cycle pulse: line complete
- busy  out  1  request in progress (state != IDLE)

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: queue_pop = queue_not_empty, combinational, the only combinational output. In the same cycle, latch:
  - line base = queue_out_addr with the low LINEWORDBITS+2 bits cleared
  - start word index = queue_out_addr[LINEWORDBITS+1:2]
  - queue_out_wordlen
  - Clear word counter. Go to REQ.
- REQ:
  - mem_rdreq=1.
  - mem_addr = base + ((start + cnt) mod LINEWORDS)*4. The index is a LINEWORDBITS-bit add that wraps naturally; the base does not change.
  - On mem_ack go to WAIT. If mem_rdvalid arrives in the same cycle as mem_ack, treat it as WAIT's completion: do the fill write and skip WAIT.
- WAIT: mem_rdreq=0. On mem_rdvalid:
  - Register fill_we=1, fill_addr=mem_addr, fill_data=mem_rddata.
  - Increment cnt.
  - If cnt was LINEWORDS-1, go to DONE; else go to REQ.
- DONE: fill_done=1 for one cycle, then IDLE.
- Ignore mem_rdvalid in IDLE, DONE, and REQ-without-ack.
- queue_pop is never asserted outside IDLE. Only one request is in flight at a time.
- Reset mid-operation aborts immediately: state IDLE, request dropped (already popped, not replayed), no fill_done.

## Timing
- Reset values: queue_pop=0 (reset_n low holds state IDLE), mem_rdreq=0, mem_addr=0, fill_we=0, fill_addr=0, fill_data=0, fill_wordlen=0, fill_done=0, busy=0.
- Pop in cycle t. mem_rdreq high from t+1.
- Ack in cycle a, rdvalid in cycle v>a: fill_we is high in cycle v+1 and lasts one cycle. The next mem_rdreq is also high from v+1.
- Ack and rdvalid both in cycle a: fill_we in a+1, next mem_rdreq in a+1.
- Zero-latency memory (ack and rdvalid every cycle): one word per cycle.
  - Line latency = LINEWORDS+2 cycles from pop to fill_done.
  - Next pop possible the cycle after fill_done.
- mem_addr and mem_rdreq are stable while mem_rdreq=1 and mem_ack=0.

## Test plan
- Aligned fill, zero-latency memory, addr 0x1000, LINEWORDS=4:
  - mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C
  - four fill_we pulses with matching data
  - fill_done 6 cycles after pop; queue_pop exactly 1 cycle
- Critical word first, addr 0x200C: fill_addr order 0x200C, 0x2000, 0x2004, 0x2008. Wrap stays inside the line; base never becomes 0x2010.
- Back-pressure: mem_ack delayed 3 cycles and rdvalid 2 cycles after ack on each word.
  - mem_rdreq and mem_addr hold steady until ack.
  - Stray rdvalid pulses in REQ (no ack) and in IDLE produce no fill_we.
- Back-to-back queue entries 0x0040 (wordlen 2) and 0x0080 (wordlen 1):
  - second pop occurs the cycle after the first fill_done
  - fill_wordlen reads 2 for the first line, then 1 for the second
- Reset asserted in WAIT after 2 of 4 words:
  - all outputs return to 0 asynchronously
  - no fill_done
  - after release with queue_not_empty=1, the new head is popped and filled normally
- Empty queue held for 20 cycles: no queue_pop, mem_rdreq=0, busy=0 throughout.
